// File: rtl/id_dispatch_sched.sv
// Dispatch scheduler: pops decoded packets, classifies by opcode, holds on WAW/full-unit hazards, issues to ALU/CAR/SEN.
// Latency: a packet popped at cycle N presents its valid at N+1 at the earliest; sustains one issue per cycle.
// Backpressure: valid holds with a stable packet until ready; no pop while a packet is held and not firing.
// Optional build macro DISPATCH_STATS_EN adds saturating stat_issued / stat_stall counters.
module id_dispatch_sched #(
    parameter int MAX_OUT = 4,
    parameter int OUT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [41:0] fifo_rd_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [41:0] alu_data,
    output logic [41:0] car_data,
    output logic [41:0] sen_data,
    output logic        alu_valid,
    output logic        car_valid,
    output logic        sen_valid,
    input  logic        alu_ready,
    input  logic        car_ready,
    input  logic        sen_ready,
    input  logic        WB_reg_write,
    input  logic [3:0]  WB_reg_addr,
    output logic [15:0] busy_mask,
    output logic        illegal_op,
`ifdef DISPATCH_STATS_EN
    output logic [15:0] stat_issued,
    output logic [15:0] stat_stall,
`endif
    output logic        sched_idle
);

    typedef enum logic {IDLE, HELD} state_t;

    localparam logic [1:0] U_ALU = 2'd0;
    localparam logic [1:0] U_CAR = 2'd1;
    localparam logic [1:0] U_SEN = 2'd2;

    state_t            state, state_n;
    logic [41:0]       pkt;
    logic [OUT_W-1:0]  out_cnt [3];
    logic [1:0]        owner [16];

    logic [4:0]        pkt_op;
    logic [3:0]        pkt_rd;
    logic              pkt_wb;
    logic [1:0]        cls_unit;
    logic              is_nop, is_ill;
    logic [OUT_W-1:0]  sel_cnt;
    logic              sel_rdy;
    logic              hazard, stall, issue, fire;
    logic              retire_hit;
    logic [2:0]        cnt_inc, cnt_dec;

    assign pkt_op   = pkt[41:37];
    assign pkt_rd   = pkt[36:33];
    assign pkt_wb   = pkt[0];
    assign alu_data = pkt;
    assign car_data = pkt;
    assign sen_data = pkt;

    // Opcode classification of the held packet
    always_comb begin
        cls_unit = U_ALU;
        is_nop   = 1'b0;
        is_ill   = 1'b0;
        case (pkt_op)
            5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b10000, 5'b10001, 5'b10010: cls_unit = U_ALU;
            5'b01011, 5'b01100, 5'b01101, 5'b01110:           cls_unit = U_CAR;
            5'b01010, 5'b01111:                               cls_unit = U_SEN;
            5'b01001:                                         is_nop   = 1'b1;
            default:                                          is_ill   = 1'b1;
        endcase
    end

    // Target unit's ready and outstanding count
    always_comb begin
        sel_cnt = out_cnt[0];
        sel_rdy = alu_ready;
        case (cls_unit)
            U_CAR: begin sel_cnt = out_cnt[1]; sel_rdy = car_ready; end
            U_SEN: begin sel_cnt = out_cnt[2]; sel_rdy = sen_ready; end
            default: ;
        endcase
    end

    // Hazard uses the registered scoreboard only: a same-cycle retire is not bypassed
    assign hazard     = pkt_wb && (busy_mask[pkt_rd] || (sel_cnt == OUT_W'(MAX_OUT)));
    assign retire_hit = WB_reg_write && busy_mask[WB_reg_addr];

    // FSM next state, pop strobe, issue and illegal pulse
    always_comb begin
        state_n    = state;
        fifo_rd_en = 1'b0;
        illegal_op = 1'b0;
        stall      = 1'b0;
        issue      = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) state_n = HELD;
            end
            HELD: begin
                if (is_nop) begin
                    state_n = IDLE;
                end else if (is_ill) begin
                    illegal_op = 1'b1;
                    state_n    = IDLE;
                end else if (hazard) begin
                    stall = 1'b1;
                end else begin
                    issue = 1'b1;
                    fire  = sel_rdy;
                    if (sel_rdy) begin
                        fifo_rd_en = !fifo_empty;
                        state_n    = fifo_empty ? IDLE : HELD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign alu_valid = issue && (cls_unit == U_ALU);
    assign car_valid = issue && (cls_unit == U_CAR);
    assign sen_valid = issue && (cls_unit == U_SEN);

    // Per-unit increment on a writeback fire, decrement on a hit retire
    always_comb begin
        cnt_inc = 3'b000;
        cnt_dec = 3'b000;
        if (fire && pkt_wb) begin
            case (cls_unit)
                U_CAR:   cnt_inc[1] = 1'b1;
                U_SEN:   cnt_inc[2] = 1'b1;
                default: cnt_inc[0] = 1'b1;
            endcase
        end
        if (retire_hit) begin
            case (owner[WB_reg_addr])
                U_CAR:   cnt_dec[1] = 1'b1;
                U_SEN:   cnt_dec[2] = 1'b1;
                default: cnt_dec[0] = 1'b1;
            endcase
        end
    end

    // State and held-packet register; a pop always reloads the packet
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pkt   <= '0;
        end else begin
            state <= state_n;
            if (fifo_rd_en) pkt <= fifo_rd_data;
        end
    end

    // Destination scoreboard, owner table and outstanding counters
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_mask <= '0;
            for (int i = 0; i < 16; i++) owner[i] <= U_ALU;
            for (int u = 0; u < 3; u++) out_cnt[u] <= '0;
        end else begin
            if (retire_hit) busy_mask[WB_reg_addr] <= 1'b0;
            if (fire && pkt_wb) begin
                busy_mask[pkt_rd] <= 1'b1;
                owner[pkt_rd]     <= cls_unit;
            end
            for (int u = 0; u < 3; u++)
                out_cnt[u] <= out_cnt[u] + OUT_W'(cnt_inc[u]) - OUT_W'(cnt_dec[u]);
        end
    end

    assign sched_idle = (state == IDLE) && (out_cnt[0] == '0) && (out_cnt[1] == '0) && (out_cnt[2] == '0);

`ifdef DISPATCH_STATS_EN
    // Saturating issue and stall event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (fire && (stat_issued != 16'hFFFF)) stat_issued <= stat_issued + 16'd1;
            if (stall && (stat_stall != 16'hFFFF)) stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_dispatch_sched.sv
// Bench for id_dispatch_sched: directed timing scenarios followed by randomized traffic.
// A queue-based FIFO model feeds the DUT; expected issues are queued at push time and popped by a monitor on every fire.
// The monitor keeps a set-based scoreboard of in-flight destinations and checks hazard rules and handshake stability.
module tb_id_dispatch_sched;

    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [41:0] fifo_rd_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [41:0] alu_data, car_data, sen_data;
    logic        alu_valid, car_valid, sen_valid;
    logic        alu_ready, car_ready, sen_ready;
    logic        WB_reg_write;
    logic [3:0]  WB_reg_addr;
    logic [15:0] busy_mask;
    logic        illegal_op;
    logic        sched_idle;
`ifdef DISPATCH_STATS_EN
    logic [15:0] stat_issued, stat_stall;
`endif

    always #5 clk = ~clk;

    id_dispatch_sched #(.MAX_OUT(MAX_OUT), .OUT_W(4)) dut (
        .clk(clk), .reset(reset),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .alu_data(alu_data), .car_data(car_data), .sen_data(sen_data),
        .alu_valid(alu_valid), .car_valid(car_valid), .sen_valid(sen_valid),
        .alu_ready(alu_ready), .car_ready(car_ready), .sen_ready(sen_ready),
        .WB_reg_write(WB_reg_write), .WB_reg_addr(WB_reg_addr),
        .busy_mask(busy_mask), .illegal_op(illegal_op),
`ifdef DISPATCH_STATS_EN
        .stat_issued(stat_issued), .stat_stall(stat_stall),
`endif
        .sched_idle(sched_idle)
    );

    logic [41:0] fifo_q [$];
    logic [41:0] exp_pkt_q [$];
    int          exp_unit_q [$];
    logic [15:0] model_busy = '0;
    int          model_owner [16];
    int          checks = 0, failures = 0;
    int          illegal_exp = 0, illegal_seen = 0, fires = 0;
    logic        pop_pend = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // 0 ALU, 1 CAR, 2 SEN, 3 NOP, 4 illegal
    function automatic int unit_of(logic [4:0] op);
        case (op)
            5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd16, 5'd17, 5'd18: return 0;
            5'd11, 5'd12, 5'd13, 5'd14: return 1;
            5'd10, 5'd15: return 2;
            5'd9: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int unit_cnt(int u);
        int n = 0;
        for (int i = 0; i < 16; i++) if (model_busy[i] && model_owner[i] == u) n++;
        return n;
    endfunction

    function automatic logic [41:0] mk(logic [4:0] op, logic [3:0] rd, logic [15:0] a, logic [15:0] b, logic wb);
        return {op, rd, a, b, wb};
    endfunction

    function automatic void refresh();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = fifo_empty ? 42'd0 : fifo_q[0];
    endfunction

    function automatic void push(logic [41:0] p);
        int u;
        fifo_q.push_back(p);
        u = unit_of(p[41:37]);
        if (u < 3) begin
            exp_unit_q.push_back(u);
            exp_pkt_q.push_back(p);
        end else if (u == 4) begin
            illegal_exp++;
        end
        refresh();
    endfunction

    task automatic step();
        logic [41:0] tmp;
        @(posedge clk);
        #1;
        if (pop_pend && fifo_q.size() != 0) tmp = fifo_q.pop_front();
        refresh();
    endtask

    task automatic do_retire(input logic [3:0] a);
        WB_reg_write = 1'b1;
        WB_reg_addr  = a;
        step();
        WB_reg_write = 1'b0;
    endtask

    function automatic logic [3:0] pick_addr();
        logic [3:0] a = 4'($urandom % 16);
        if (($urandom % 4) != 0 && model_busy != '0)
            while (!model_busy[a]) a = a + 4'd1;
        return a;
    endfunction

    function automatic logic [41:0] rand_pkt();
        logic [4:0] legal [16] = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                   5'd16, 5'd17, 5'd18, 5'd11, 5'd13, 5'd10, 5'd15, 5'd9};
        logic [4:0] op = (($urandom % 8) == 0) ? 5'($urandom % 32) : legal[$urandom % 16];
        return mk(op, 4'($urandom % 8), 16'($urandom), 16'($urandom), ($urandom % 4) != 0);
    endfunction

    logic [2:0]  m_v, m_r, prev_v, prev_r;
    logic [41:0] m_d [3];
    logic [41:0] prev_d [3];
    logic        m_fired, m_hz;
    logic [41:0] m_fd;
    int          m_fu, m_eu;
    logic [41:0] m_ep;

    // Monitor: scoreboard compare on every fire, handshake stability and set-based busy model
    always @(negedge clk) begin
        if (reset) begin
            model_busy = '0;
            pop_pend   = 1'b0;
            prev_v     = '0;
        end else begin
            pop_pend = fifo_rd_en;
            chk("busy_mask", busy_mask, model_busy);
            m_v = {sen_valid, car_valid, alu_valid};
            m_r = {sen_ready, car_ready, alu_ready};
            m_d[0] = alu_data; m_d[1] = car_data; m_d[2] = sen_data;
            if (m_v != '0) chk("valid_onehot", $countones(m_v), 1);
            if (illegal_op) illegal_seen++;
            m_fired = 1'b0;
            for (int u = 0; u < 3; u++) begin
                if (prev_v[u] && !prev_r[u]) begin
                    chk("valid_hold", m_v[u], 1'b1);
                    chk("data_hold", m_d[u], prev_d[u]);
                end
                if (m_v[u] && m_r[u]) begin
                    fires++;
                    if (exp_unit_q.size() == 0) begin
                        chk("unexpected_fire", 1, 0);
                    end else begin
                        m_eu = exp_unit_q.pop_front();
                        m_ep = exp_pkt_q.pop_front();
                        chk("fire_unit", u, m_eu);
                        chk("fire_data", m_d[u], m_ep);
                    end
                    if (m_d[u][0]) begin
                        m_hz = model_busy[m_d[u][36:33]] || (unit_cnt(u) >= MAX_OUT);
                        chk("fire_hazard_free", m_hz, 1'b0);
                    end
                    m_fired = 1'b1;
                    m_fu    = u;
                    m_fd    = m_d[u];
                end
            end
            if (WB_reg_write && model_busy[WB_reg_addr]) model_busy[WB_reg_addr] = 1'b0;
            if (m_fired && m_fd[0]) begin
                model_busy[m_fd[36:33]]  = 1'b1;
                model_owner[m_fd[36:33]] = m_fu;
            end
            prev_v = m_v;
            prev_r = m_r;
            prev_d = m_d;
        end
    end

    logic [41:0] p0, p1, pk [5];
    logic [15:0] stall_base;
    logic        drained;

    initial begin
        reset = 1'b1;
        alu_ready = 1'b0; car_ready = 1'b0; sen_ready = 1'b0;
        WB_reg_write = 1'b0; WB_reg_addr = '0;
        stall_base = '0;
        refresh();
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", busy_mask, 16'h0);
        chk("rst_valids", {alu_valid, car_valid, sen_valid}, 3'b000);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_illegal", illegal_op, 1'b0);
        chk("rst_idle", sched_idle, 1'b1);
        step();
        reset = 1'b0;

        // ADD rd=3 issue with one-cycle pop-to-valid latency
        step();
        alu_ready = 1'b1;
        p0 = mk(5'b00011, 4'd3, 16'hABCD, 16'h1234, 1'b1);
        push(p0);
        @(negedge clk); chk("t1_rd_en", fifo_rd_en, 1'b1);
        step();
        @(negedge clk); chk("t1_alu_valid", alu_valid, 1'b1); chk("t1_alu_data", alu_data, p0);
        step();
        @(negedge clk); chk("t1_busy", busy_mask, 16'h0008); chk("t1_valid_off", alu_valid, 1'b0);

        // WAW hazard on rd=3 held until retire, issue the cycle after
        step();
        p1 = mk(5'b00000, 4'd3, 16'h0001, 16'h0002, 1'b1);
        push(p1);
        @(negedge clk);
`ifdef DISPATCH_STATS_EN
        stall_base = stat_stall;
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk); chk("t2_stall", alu_valid, 1'b0);
        end
        step();
        WB_reg_write = 1'b1; WB_reg_addr = 4'd3;
        @(negedge clk); chk("t2_no_bypass", alu_valid, 1'b0);
        step();
        WB_reg_write = 1'b0;
        @(negedge clk); chk("t2_issue", alu_valid, 1'b1); chk("t2_data", alu_data, p1);
`ifdef DISPATCH_STATS_EN
        chk("t2_stat_stall", stat_stall, stall_base + 16'd4);
`endif
        step();
        do_retire(4'd3);

        // Car stream back-to-back, no writeback
        car_ready = 1'b1;
        for (int k = 0; k < 4; k++) pk[k] = mk(5'(11 + k), 4'(k), 16'(k * 7), 16'h55AA, 1'b0);
        for (int k = 0; k < 4; k++) push(pk[k]);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk); chk("t3_car_valid", car_valid, 1'b1); chk("t3_car_data", car_data, pk[k]);
        end
        step();
        @(negedge clk); chk("t3_car_done", car_valid, 1'b0); chk("t3_busy", busy_mask, 16'h0);

        // Sensor backpressure: valid and data stable while ready is low
        step();
        sen_ready = 1'b0;
        p0 = mk(5'b01010, 4'd7, 16'h1111, 16'h2222, 1'b0);
        p1 = mk(5'b01111, 4'd8, 16'h3333, 16'h4444, 1'b0);
        push(p0); push(p1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk); chk("t4_sen_valid", sen_valid, 1'b1); chk("t4_sen_data", sen_data, p0);
        end
        step();
        sen_ready = 1'b1;
        step();
        @(negedge clk); chk("t4_second", sen_valid, 1'b1); chk("t4_second_data", sen_data, p1);
        step();
        @(negedge clk); chk("t4_done", sen_valid, 1'b0);

        // Illegal opcode pulse and NOP consumption
        step();
        push(mk(5'b11111, 4'd1, 16'h0, 16'h0, 1'b1));
        push(mk(5'b01001, 4'd2, 16'h0, 16'h0, 1'b1));
        @(negedge clk);
        step();
        @(negedge clk); chk("t5_illegal", illegal_op, 1'b1); chk("t5_no_valid", {alu_valid, car_valid, sen_valid}, 3'b000);
        step();
        @(negedge clk); chk("t5_pulse_end", illegal_op, 1'b0);
        step();
        @(negedge clk); chk("t5_nop_no_valid", {alu_valid, car_valid, sen_valid}, 3'b000);
        step();
        @(negedge clk); chk("t5_idle", sched_idle, 1'b1);

        // Outstanding limit: 5th ALU writeback stalls until one retires
        step();
        alu_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pk[k] = mk(5'b00011, 4'(k + 1), 16'(k), 16'(k + 100), 1'b1);
            push(pk[k]);
        end
        for (int i = 0; i < 8; i++) step();
        @(negedge clk); chk("t6_busy4", busy_mask, 16'h001E); chk("t6_full_stall", alu_valid, 1'b0);
        chk("t6_not_idle", sched_idle, 1'b0);
        step();
        do_retire(4'd2);
        @(negedge clk); chk("t6_issue5", alu_valid, 1'b1); chk("t6_data5", alu_data, pk[4]);
        step();
        @(negedge clk); chk("t6_busy_after", busy_mask, 16'h003A);
        step();
        do_retire(4'd1); do_retire(4'd3); do_retire(4'd4); do_retire(4'd5);

        // Randomized traffic against the reference scoreboard
        for (int c = 0; c < 3000; c++) begin
            step();
            alu_ready = ($urandom % 4) != 0;
            car_ready = ($urandom % 3) != 0;
            sen_ready = ($urandom % 2) != 0;
            WB_reg_write = ($urandom % 3) == 0;
            WB_reg_addr  = pick_addr();
            if (fifo_q.size() < 3 && ($urandom % 2) != 0) push(rand_pkt());
        end
        drained = 1'b0;
        for (int c = 0; c < 3000 && !drained; c++) begin
            step();
            alu_ready = 1'b1; car_ready = 1'b1; sen_ready = 1'b1;
            WB_reg_write = 1'b1;
            WB_reg_addr  = pick_addr();
            drained = (fifo_q.size() == 0) && (exp_unit_q.size() == 0);
        end
        chk("drain_done", drained, 1'b1);
        step();
        WB_reg_write = 1'b0;
        repeat (3) step();
        for (int a = 0; a < 16; a++) if (model_busy[a]) do_retire(4'(a));
        step();
        @(negedge clk);
        chk("end_busy", busy_mask, 16'h0);
        chk("end_idle", sched_idle, 1'b1);
        chk("end_illegal_count", illegal_seen, illegal_exp);
`ifdef DISPATCH_STATS_EN
        chk("end_stat_issued", stat_issued, 64'(fires));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_dispatch_sched.md
Name: id_dispatch_sched

Overview:
Dispatch scheduler between the ID stage's 42-bit decode FIFO and the three execution units: ALU, car-control and sensor.
- Pops decoded packets and classifies each by opcode.
- Holds a packet on write-after-write hazards using a 16-entry destination scoreboard, and when a unit's outstanding limit is reached.
- Issues to the selected unit over a valid/ready handshake.
- Retires scoreboard entries from the writeback port (WB_reg_write / WB_reg_addr).

Parameters:
MAX_OUT, 4, max in-flight writeback packets per unit (1..15)
OUT_W, 4, width of per-unit outstanding counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
fifo_rd_data  in  42  show-ahead FIFO head: [41:37] opcode, [36:33] rd, [32:17] op_a, [16:1] op_b, [0] wb_en
fifo_empty  in  1  FIFO empty
fifo_rd_en  out  1  pop strobe
alu_data / car_data / sen_data  out  42  issued packet (copy of held packet)
alu_valid / car_valid / sen_valid  out  1  issue valid
alu_ready / car_ready / sen_ready  in  1  unit accepts
WB_reg_write  in  1  retire strobe
WB_reg_addr  in  4  register being retired
busy_mask  out  16  scoreboard (bit n = rd n in flight)
illegal_op  out  1  one-cycle pulse on undefined opcode
sched_idle  out  1  no held packet and all outstanding counts zero

Behaviour:
Reset: state IDLE, packet register 0, busy_mask 0, all outstanding counters 0. All valids, fifo_rd_en and illegal_op are 0; sched_idle is 1. Reset mid-handshake drops the held packet.

Classes:
- ALU: MOV 00000, LD 00001, ADD 00011, SUB 00100, AND 00101, OR 00110, NOT 00111, JMP 01000, CMP 10000, MULT 10001, DIV 10010.
- CAR: 01011..01110.
- SEN: OB_CHECK 01010, VELOCITY_GUARD 01111.
- NOP: 01001.
- All other opcodes are illegal.

States:
- IDLE: fifo_rd_en = !fifo_empty. On a pop, latch fifo_rd_data and go to HELD.
- HELD (packet latched; evaluated every cycle):
  - NOP: drop, go to IDLE.
  - Illegal: pulse illegal_op, drop, go to IDLE.
  - Stall (stay in HELD, all valids 0) if wb_en=1 and either busy_mask[rd]=1 or the target unit's outstanding count == MAX_OUT.
  - Otherwise assert the target unit's valid with its data = held packet. Valid stays asserted and the packet stays stable until ready; valid never drops without a handshake.
- Fire (valid && ready):
  - If wb_en: set busy_mask[rd], increment that unit's outstanding count, record owner[rd] = unit (2-bit owner table).
  - If !fifo_empty, pop in the same cycle and stay in HELD with the new packet; else go to IDLE.
  - Back-to-back issue therefore sustains 1 packet per cycle.

Latency: a packet pops at cycle N; its valid is earliest at cycle N+1.

Retire (WB_reg_write=1):
- If busy_mask[addr]=1: clear it and decrement outstanding[owner[addr]].
- If busy_mask[addr]=0: ignore (no underflow).

Boundary rules:
- Retire and fire in the same cycle to the same unit: the count is unchanged (+1-1).
- Retire of rd while a packet is held on rd: the hazard check uses the registered busy_mask, so issue occurs the following cycle (no bypass).
- Packets with wb_en=0 never touch the scoreboard or the counters.
- The outstanding count never exceeds MAX_OUT.
- Only one valid is ever asserted at a time.

Optional Feature:
DISPATCH_STATS_EN:
- Defined: adds outputs stat_issued[15:0] (increments on each fire) and stat_stall[15:0] (increments each HELD cycle with a hazard or full-unit stall). Both saturate at 16'hFFFF and are cleared by reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then FIFO holds ADD rd=3 wb_en=1 op_a=ABCD op_b=1234 -> fifo_rd_en pulses, next cycle alu_valid=1 with alu_data equal to the packet; with alu_ready=1, busy_mask=16'h0008.
- ADD rd=3 in flight, second MOV rd=3 wb_en=1 -> alu_valid stays 0 until WB_reg_write with WB_reg_addr=3; issue follows on the next cycle; STALL stats count those cycles.
- Stream MOVE_LEFT, MOVE_RIGHT, STOP, CONTINUE (wb_en=0), car_ready=1 -> car_valid high for 4 consecutive cycles, busy_mask stays 0.
- OB_CHECK then VELOCITY_GUARD with sen_ready=0 for 3 cycles -> sen_valid held 3 cycles with sen_data stable, then 2 fires.
- Opcode 11111 -> illegal_op one-cycle pulse, no valid; NOP -> consumed with no valid.
- MAX_OUT=4: 5 ALU wb packets to rd 1..5 with no retire -> 4 issue and the 5th stalls; WB_reg_addr=2 -> 5th issues one cycle later.
